// File: rtl/conv_out_framer.sv
// Frames a flat stream of LANES-byte channel-group beats into pixel rows and frames,
// padding partial channel groups. Optional stall/starve counters: CONV_OUT_FRAMER_STATS_EN.
module conv_out_framer #(
  parameter int LANES  = 8,
  parameter int DATA_W = LANES * 8,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  in_channel,
  input  logic [DIM_W-1:0]  matrix_col,
  input  logic [DIM_W-1:0]  matrix_row,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LANES-1:0]  m_keep,
  output logic              m_last_row,
  output logic              m_last,
  output logic              busy,
  output logic              done
`ifdef CONV_OUT_FRAMER_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       starve_cnt
`endif
);

  localparam int LOG2 = $clog2(LANES);

  // state | meaning
  // IDLE  | waiting for start; geometry inputs sampled here
  // RUN   | accepting input beats
  // DRAIN | final beat buffered, waiting for its output handshake
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0] grp_last_q, col_last_q, row_last_q;
  logic [LOG2-1:0]  rem_q;
  logic [DIM_W-1:0] grp_q, grp_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;

  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic [LANES-1:0]  m_keep_q;
  logic              m_last_row_q;
  logic              m_last_q;
  logic              done_q, done_d;

  logic              geom_ok;
  logic [DIM_W:0]    ch_round;
  logic [DIM_W-1:0]  groups_in;
  logic              accept_start;
  logic              in_hs;
  logic              out_hs;
  logic              last_grp, last_col, last_rowi;
  logic              pad_beat;
  logic [LANES-1:0]  keep_d;
  logic [DATA_W-1:0] data_d;

  // One extra bit so the round-up cannot wrap at maximum in_channel.
  always_comb begin
    geom_ok   = (in_channel != '0) && (matrix_col != '0) && (matrix_row != '0);
    ch_round  = {1'b0, in_channel} + (DIM_W+1)'(LANES - 1);
    groups_in = DIM_W'(ch_round >> LOG2);
  end

  assign s_ready = (state_q == RUN) && (!m_valid_q || m_ready);
  assign in_hs   = s_valid && s_ready;
  assign out_hs  = m_valid_q && m_ready;

  assign last_grp  = (grp_q == grp_last_q);
  assign last_col  = (col_q == col_last_q);
  assign last_rowi = (row_q == row_last_q);

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (geom_ok) begin
            state_d      = RUN;
            accept_start = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_hs && last_grp && last_col && last_rowi) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_last_q <= '0;
      col_last_q <= '0;
      row_last_q <= '0;
      rem_q      <= '0;
    end else if (accept_start) begin
      grp_last_q <= groups_in - 1'b1;
      col_last_q <= matrix_col - 1'b1;
      row_last_q <= matrix_row - 1'b1;
      rem_q      <= in_channel[LOG2-1:0];
    end
  end

  always_comb begin
    grp_d = grp_q;
    col_d = col_q;
    row_d = row_q;
    if (accept_start) begin
      grp_d = '0;
      col_d = '0;
      row_d = '0;
    end else if (in_hs) begin
      if (last_grp) begin
        grp_d = '0;
        if (last_col) begin
          col_d = '0;
          row_d = last_rowi ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        grp_d = grp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      grp_q <= grp_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Partial last group: only the low rem bytes are real channels.
  always_comb begin
    pad_beat = last_grp && (rem_q != '0);
    keep_d   = '0;
    data_d   = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_d[i] = !pad_beat || (LOG2'(i) < rem_q);
      data_d[i*8 +: 8] = keep_d[i] ? s_data[i*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_row_q <= 1'b0;
      m_last_q     <= 1'b0;
    end else if (in_hs) begin
      m_valid_q    <= 1'b1;
      m_data_q     <= data_d;
      m_keep_q     <= keep_d;
      m_last_row_q <= last_grp && last_col;
      m_last_q     <= last_grp && last_col && last_rowi;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;
  assign m_last_row = m_last_row_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

`ifdef CONV_OUT_FRAMER_STATS_EN
  logic [31:0] stall_cnt_q, starve_cnt_q;
  logic        stats_clr;

  assign stats_clr = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      stall_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (busy && m_valid_q && !m_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if ((state_q == RUN) && s_ready && !s_valid && (starve_cnt_q != '1)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign starve_cnt = starve_cnt_q;
`endif

endmodule

// File: tb/tb_conv_out_framer.sv
// Directed bench for conv_out_framer: framing, padding, backpressure, zero geometry,
// mid-frame reset, ignored mid-frame start/geometry changes and back-to-back frames.
module tb_conv_out_framer;
  localparam int LANES  = 8;
  localparam int DATA_W = 64;
  localparam int DIM_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [DIM_W-1:0]  in_channel, matrix_col, matrix_row;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [LANES-1:0]  m_keep;
  logic              m_last_row, m_last, busy, done;
`ifdef CONV_OUT_FRAMER_STATS_EN
  logic [31:0]       stall_cnt, starve_cnt;
`endif

  int checks = 0;
  int errors = 0;

  conv_out_framer #(.LANES(LANES), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_channel(in_channel), .matrix_col(matrix_col), .matrix_row(matrix_row),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last_row(m_last_row), .m_last(m_last), .busy(busy), .done(done)
`ifdef CONV_OUT_FRAMER_STATS_EN
    , .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Input beat k; padded byte positions carry 0xFF so masking is visible.
  function automatic logic [DATA_W-1:0] pat(input int k, input int groups, input int rem);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((k % groups == groups - 1) && rem != 0 && i >= rem) d[i*8 +: 8] = 8'hFF;
      else d[i*8 +: 8] = 8'(k * LANES + i + 1);
    end
    return d;
  endfunction

  // Caller sits at a negedge; returns at the negedge where done must be high.
  task automatic run_frame(input int ch, input int cols, input int rows,
                           input bit rnd, input bit gaps, input bit disturb, input string nm);
    int groups, rem, total, in_k, out_k, cyc, done_seen, k, g, c, r;
    bit stall_prev, first, disturbed, elr, el;
    logic [DATA_W-1:0] pd, ed, pin;
    logic [LANES-1:0]  pk, ek;
    logic              plr, pl;
    int q[$];
    groups = (ch + LANES - 1) / LANES;
    rem    = ch % LANES;
    total  = groups * cols * rows;
    in_k = 0; out_k = 0; cyc = 0; done_seen = 0;
    stall_prev = 0; first = 1; disturbed = 0;
    pd = '0; pk = '0; plr = 0; pl = 0;
    in_channel = DIM_W'(ch); matrix_col = DIM_W'(cols); matrix_row = DIM_W'(rows);
    start = 1; s_valid = 0; m_ready = 1;
    while (out_k < total && cyc < 20000) begin
      @(negedge clk);
      start = 0;
      if (disturb && in_k == 5 && !disturbed) begin
        start = 1; in_channel = 16'd3; matrix_col = 16'd1; matrix_row = 16'd1;
        disturbed = 1;
      end
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_keep !== pk || m_last_row !== plr || m_last !== pl) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b d=%h k=%h lr=%b l=%b, required v=1 d=%h k=%h lr=%b l=%b",
                   nm, m_valid, m_data, m_keep, m_last_row, m_last, pd, pk, plr, pl);
        end
      end
      if (done === 1'b1) done_seen++;
      s_valid = (in_k < total) && (!gaps || $urandom_range(0, 2) != 0);
      s_data  = pat(in_k, groups, rem);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (first && !gaps) begin
        checks++;
        if (s_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s first_ready: got s_ready=%b, required 1", nm, s_ready);
        end
      end
      first = 0;
      if (s_valid && s_ready) begin
        q.push_back(in_k);
        in_k++;
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s beat_extra: got an output beat, required none pending", nm);
        end else begin
          k  = q.pop_front();
          g  = k % groups;
          c  = (k / groups) % cols;
          r  = k / (groups * cols);
          ek = (g == groups - 1 && rem != 0) ? LANES'((1 << rem) - 1) : {LANES{1'b1}};
          pin = pat(k, groups, rem);
          ed = '0;
          for (int i = 0; i < LANES; i++) ed[i*8 +: 8] = ek[i] ? pin[i*8 +: 8] : 8'h00;
          elr = (g == groups - 1) && (c == cols - 1);
          el  = elr && (r == rows - 1);
          if (m_data !== ed || m_keep !== ek || m_last_row !== elr || m_last !== el) begin
            errors++;
            $display("FAIL %s beat%0d: got d=%h k=%h lr=%b l=%b, required d=%h k=%h lr=%b l=%b",
                     nm, k + 1, m_data, m_keep, m_last_row, m_last, ed, ek, elr, el);
          end
        end
        out_k++;
      end
      stall_prev = m_valid && !m_ready;
      pd = m_data; pk = m_keep; plr = m_last_row; pl = m_last;
      cyc++;
    end
    checks++;
    if (out_k != total || in_k != total || q.size() != 0) begin
      errors++;
      $display("FAIL %s beat_count: got in=%0d out=%0d pending=%0d, required %0d", nm, in_k, out_k, q.size(), total);
    end
    @(negedge clk);
    s_valid = 0; start = 0; m_ready = 1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || done_seen != 0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b busy=%b m_valid=%b early_done=%0d, required 1 0 0 0",
               nm, done, busy, m_valid, done_seen);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; s_valid = 0; m_ready = 1; s_data = '0;
    in_channel = '0; matrix_col = '0; matrix_row = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_ready !== 0 || m_valid !== 0 || m_data !== '0 || m_keep !== '0 ||
        m_last_row !== 0 || m_last !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b v=%b d=%h k=%h lr=%b l=%b busy=%b done=%b, required all 0",
               s_ready, m_valid, m_data, m_keep, m_last_row, m_last, busy, done);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    @(negedge clk);
    run_frame(32, 14, 14, 0, 0, 0, "full_frame");
  endtask

  task automatic test_padding();
    @(negedge clk);
    run_frame(20, 2, 1, 0, 0, 0, "padding");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    run_frame(32, 14, 14, 1, 1, 0, "backpressure");
  endtask

  task automatic test_zero_geom();
    bit bad;
    @(negedge clk);
    in_channel = 16'd32; matrix_col = 16'd14; matrix_row = 16'd0; start = 1;
    @(negedge clk);
    start = 0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_geom_done: got done=%b busy=%b m_valid=%b, required 1 0 0", done, busy, m_valid);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL zero_geom_quiet: got activity after done, required none");
    end
  endtask

  task automatic test_reset_mid();
    int cnt, cyc;
    bit bad;
    @(negedge clk);
    in_channel = 16'd32; matrix_col = 16'd14; matrix_row = 16'd14; start = 1;
    cnt = 0; cyc = 0;
    while (cnt < 100 && cyc < 1000) begin
      @(negedge clk);
      start = 0; s_valid = 1; m_ready = 1; s_data = {8{8'hA5}};
      #1;
      if (s_valid && s_ready) cnt++;
      cyc++;
    end
    checks++;
    if (cnt != 100) begin
      errors++;
      $display("FAIL reset_mid_fill: got %0d beats accepted, required 100", cnt);
    end
    @(negedge clk);
    rst = 1; s_valid = 0;
    @(negedge clk);
    checks++;
    if (m_valid !== 0 || busy !== 0 || s_ready !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_mid_clear: got v=%b busy=%b rdy=%b done=%b, required 0 0 0 0", m_valid, busy, s_ready, done);
    end
    rst = 0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || m_valid !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_mid_stale: got done or m_valid after reset, required none");
    end
    run_frame(8, 1, 1, 0, 0, 0, "after_reset");
  endtask

  task automatic test_ignore_midframe();
    @(negedge clk);
    run_frame(20, 3, 2, 1, 0, 1, "ignore_midframe");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_frame(20, 2, 1, 0, 0, 0, "b2b_first");
    run_frame(8, 1, 2, 0, 0, 0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_padding();
    test_backpressure();
    test_zero_geom();
    test_reset_mid();
    test_ignore_midframe();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_out_framer.md
Name: conv_out_framer

Overview:
- Parametrised successor to the conv output stage; sits between the systolic-array result stream and the output DMA/writeback.
- Accepts a flat stream of LANES-byte beats, one channel group per beat, in pixel-major order.
- Frames the stream using runtime geometry (in_channel x matrix_col x matrix_row) and pads partial channel groups.
- Emits byte-keep, end-of-row and end-of-frame markers, plus busy/done status.

Parameters:
- LANES, 8, bytes per beat; must be a power of 2, range 2..64.
- DATA_W, LANES*8, data bus width in bits.
- DIM_W, 16, width of the geometry inputs and internal counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- in_channel  in  DIM_W  channels per pixel.
- matrix_col  in  DIM_W  pixels per row.
- matrix_row  in  DIM_W  rows per frame.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  DATA_W  input beat; byte i carries channel g*LANES+i.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat ready.
- m_data  out  DATA_W  output beat.
- m_keep  out  LANES  byte-valid mask.
- m_last_row  out  1  final beat of a pixel row.
- m_last  out  1  final beat of the frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, m_keep=0, m_last_row=0, m_last=0, busy=0, done=0. FSM returns to IDLE and all counters clear.
- Geometry capture: in IDLE, start latches the geometry. Later changes on the geometry inputs have no effect until the next frame.
- Group count: groups = (in_channel + LANES-1) >> log2(LANES).
- Remainder: rem = in_channel & (LANES-1); a value of 0 means a full group.
- FSM states are IDLE, RUN, DRAIN:
  - IDLE -> RUN on start when all three geometry values are nonzero.
  - IDLE with start and any geometry value zero: stays in IDLE, pulses done the next cycle, makes no transfers.
  - RUN -> DRAIN on the cycle the final input beat is accepted.
  - DRAIN -> IDLE on the final output handshake; done pulses in the cycle after that handshake.
  - start is ignored in RUN and DRAIN.
- Counters: grp (0..groups-1), col (0..matrix_col-1), row (0..matrix_row-1).
  - All advance only on an input handshake.
  - grp wraps to 0 and increments col; col wraps to 0 and increments row.
- Output stage is a single register with full throughput.
  - s_ready = (state==RUN) && (!m_valid || m_ready).
  - Latency is 1 cycle from input handshake to m_valid.
  - m_data, m_keep and the flags hold stable while m_valid && !m_ready.
- Keep and padding:
  - m_keep is all ones except on beats with grp==groups-1 and rem!=0; those beats get m_keep = (1<<rem)-1.
  - Bytes with keep=0 are forced to 0 in m_data, whatever s_data carries.
- Flags:
  - m_last_row=1 on the beat with grp==groups-1 and col==matrix_col-1.
  - m_last=1 when m_last_row is set and row==matrix_row-1.
- Arithmetic: counter compares are unsigned DIM_W bits. The total beat count is never formed, so there is no overflow at maximum geometry.
- Reset mid-frame: the buffered beat is discarded, no done pulse is produced, and the FSM returns to IDLE on the next edge.
- Back-to-back frames: start may be asserted in the cycle done is high (FSM already in IDLE). The new frame begins with no bubble beyond that cycle.

Optional Feature:
- Macro: CONV_OUT_FRAMER_STATS_EN.
- When defined:
  - Adds output stall_cnt [31:0], counting cycles with m_valid && !m_ready during busy.
  - Adds output starve_cnt [31:0], counting cycles in RUN with s_ready && !s_valid.
  - Both counters clear on rst and on each accepted start, and saturate at 2^32-1.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- LANES=8, in_channel=32, col=row=14, s_valid and m_ready tied 1:
  - exactly 784 output beats, every m_keep=0xFF;
  - m_last_row on beats 56,112,...,784;
  - m_last only on beat 784, done 1 cycle after it;
  - data matches input order.
- in_channel=20, col=2, row=1: 6 beats; beats 3 and 6 have m_keep=0x0F with bytes 4-7 zero even when the input carries 0xFF there.
- m_ready pseudo-random at 50% with s_valid gaps, using frame 1's geometry: no lost or duplicated beats, stalled outputs stay stable, 784 beats total.
- start with matrix_row=0: done pulses the next cycle, m_valid never rises, busy stays 0.
- rst asserted after 100 beats, then a new start with in_channel=8, col=row=1: one beat out with m_last=1 and m_keep=0xFF; no stale data and no done from the aborted frame.
- start pulsed mid-frame, and geometry inputs changed mid-frame: no effect, frame completes with the originally latched counts.
